// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-request load/store unit controller.
// Takes one load or store at a time and checks its width code and alignment.
// It drives one aligned memory access with lane-shifted data and byte enables.
// For a load it extends the returned data, and it reports one completion.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         request handshake (ready only in IDLE)
//   req_store, req_funct3         1 = store; RISC-V width/sign code
//   req_addr, req_wdata           byte address, LSB-aligned store data
//   mem_read / mem_write          memory strobes, held for the whole access
//   mem_address                   word-aligned address
//   mem_wdata, mem_byte_enable    lane-shifted store data, active lanes
//   mem_rdata, mem_resp           read data and completion from memory
//   done_valid                    one-cycle completion pulse
//   done_rdata                    extended load result (0 for stores/errors)
//   done_misaligned/timeout/illegal  error flags, held until the next completion
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for a request
// S_ACCESS | strobe asserted, waiting for mem_resp or the access timer
// S_DONE   | done_valid pulse; the result registers take new values on entry

module lsu_ctrl #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [XLEN-1:0]   mem_address,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_byte_enable,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_resp,
   output logic              done_valid,
   output logic [XLEN-1:0]   done_rdata,
   output logic              done_misaligned,
   output logic              done_timeout,
   output logic              done_illegal
);

   localparam int NB       = XLEN / 8;
   localparam int OW       = $clog2(NB);
   localparam bit TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam int CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TMR_INIT = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("lsu_ctrl: XLEN must be 32 or 64");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_store;
   logic [2:0]        r_funct3;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [CW-1:0]     r_tmr;
   logic [XLEN-1:0]   r_done_rdata;
   logic              r_done_mis;
   logic              r_done_to;
   logic              r_done_ill;

   logic              w_req_illegal;
   logic              w_req_misal;
   logic              w_accept;
   logic              w_capture;
   logic [XLEN-1:0]   w_rdata_nxt;
   logic              w_mis_nxt;
   logic              w_to_nxt;
   logic              w_ill_nxt;
   logic              w_access;
   logic [OW-1:0]     w_off;
   logic [OW+2:0]     w_shamt;
   logic [XLEN-1:0]   w_rshift;
   logic [XLEN-1:0]   w_load_ext;
   logic [NB-1:0]     w_be_mask;

   // Request decode on the live inputs, so an error completes one cycle after accept.
   always_comb begin
      w_req_illegal = 1'b0;
      w_req_misal   = 1'b0;
      if (req_store)
         w_req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11 && XLEN == 32);
      else
         w_req_illegal = (req_funct3 == 3'b111) ||
                         ((req_funct3 == 3'b011 || req_funct3 == 3'b110) && XLEN == 32);
      case (req_funct3[1:0])
         2'b00:   w_req_misal = 1'b0;
         2'b01:   w_req_misal = req_addr[0];
         2'b10:   w_req_misal = |req_addr[1:0];
         default: w_req_misal = |req_addr[2:0];
      endcase
   end

   assign w_off    = r_addr[OW-1:0];
   assign w_shamt  = {w_off, 3'b000};
   assign w_rshift = mem_rdata >> w_shamt;

   // Sized casts of signed operands sign-extend; of unsigned operands, zero-extend.
   always_comb begin
      case (r_funct3)
         3'b000:  w_load_ext = XLEN'($signed(w_rshift[7:0]));
         3'b001:  w_load_ext = XLEN'($signed(w_rshift[15:0]));
         3'b010:  w_load_ext = XLEN'($signed(w_rshift[31:0]));
         3'b100:  w_load_ext = XLEN'(w_rshift[7:0]);
         3'b101:  w_load_ext = XLEN'(w_rshift[15:0]);
         3'b110:  w_load_ext = XLEN'(w_rshift[31:0]);
         default: w_load_ext = w_rshift;
      endcase
   end

   always_comb begin
      case (r_funct3[1:0])
         2'b00:   w_be_mask = NB'(1);
         2'b01:   w_be_mask = NB'(3);
         2'b10:   w_be_mask = NB'(15);
         default: w_be_mask = NB'(8'hFF);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_store      <= 1'b0;
         r_funct3     <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_tmr        <= '0;
         r_done_rdata <= '0;
         r_done_mis   <= 1'b0;
         r_done_to    <= 1'b0;
         r_done_ill   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_tmr    <= CW'(TMR_INIT);
         end else if (r_state == S_ACCESS && r_tmr != '0) begin
            r_tmr <= r_tmr - CW'(1);
         end
         if (w_capture) begin
            r_done_rdata <= w_rdata_nxt;
            r_done_mis   <= w_mis_nxt;
            r_done_to    <= w_to_nxt;
            r_done_ill   <= w_ill_nxt;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_rdata_nxt = '0;
      w_mis_nxt   = 1'b0;
      w_to_nxt    = 1'b0;
      w_ill_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_accept = 1'b1;
               if (w_req_illegal) begin
                  w_state_nxt = S_DONE;
                  w_capture   = 1'b1;
                  w_ill_nxt   = 1'b1;
               end else if (w_req_misal) begin
                  w_state_nxt = S_DONE;
                  w_capture   = 1'b1;
                  w_mis_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            // The timer reads zero in the last allowed cycle; a response that
            // arrives in that same cycle still completes normally.
            if (mem_resp) begin
               w_state_nxt = S_DONE;
               w_capture   = 1'b1;
               w_rdata_nxt = r_store ? '0 : w_load_ext;
            end else if (TO_EN && r_tmr == '0) begin
               w_state_nxt = S_DONE;
               w_capture   = 1'b1;
               w_to_nxt    = 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_access        = (r_state == S_ACCESS);
   assign req_ready       = (r_state == S_IDLE);
   assign mem_read        = w_access & ~r_store;
   assign mem_write       = w_access & r_store;
   assign mem_address     = w_access ? {r_addr[XLEN-1:OW], {OW{1'b0}}} : '0;
   assign mem_wdata       = w_access ? (r_wdata << w_shamt) : '0;
   assign mem_byte_enable = w_access ? (w_be_mask << w_off) : '0;
   assign done_valid      = (r_state == S_DONE);
   assign done_rdata      = r_done_rdata;
   assign done_misaligned = r_done_mis;
   assign done_timeout    = r_done_to;
   assign done_illegal    = r_done_ill;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl (XLEN=32, TIMEOUT_CYCLES=4).
// Stimulus pushes the expected completion and memory access, then drives the request.
// Two monitors compare the DUT outputs against those queues.

module tb_lsu_ctrl;

   localparam int XLEN = 32;
   localparam int TO   = 4;
   localparam int K_OK = 0, K_MIS = 1, K_ILL = 2, K_TO = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_store = 1'b0;
   logic [2:0]        req_funct3 = '0;
   logic [XLEN-1:0]   req_addr = '0;
   logic [XLEN-1:0]   req_wdata = '0;
   logic              mem_read, mem_write;
   logic [XLEN-1:0]   mem_address, mem_wdata;
   logic [XLEN/8-1:0] mem_byte_enable;
   logic [XLEN-1:0]   mem_rdata = '0;
   logic              mem_resp = 1'b0;
   logic              done_valid;
   logic [XLEN-1:0]   done_rdata;
   logic              done_misaligned, done_timeout, done_illegal;

   lsu_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .done_valid(done_valid), .done_rdata(done_rdata),
      .done_misaligned(done_misaligned), .done_timeout(done_timeout),
      .done_illegal(done_illegal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        mis, to, ill;
      int          cyc;
   } done_exp_t;

   typedef struct {
      logic        rd, wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata, wmask;
      int          ncyc;
   } mem_exp_t;

   done_exp_t done_q[$];
   mem_exp_t  mem_q[$];
   done_exp_t mon_d;
   mem_exp_t  mon_m;
   int        n_checks = 0;
   int        n_fail = 0;
   int        strobe_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done_valid) begin
         if (done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: actual=done_valid 1 required=no completion (cycle %0d)", cyc);
         end else begin
            mon_d = done_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(mon_d.cyc));
            check("done_rdata", done_rdata, mon_d.rdata);
            check("done_misaligned", done_misaligned, mon_d.mis);
            check("done_timeout", done_timeout, mon_d.to);
            check("done_illegal", done_illegal, mon_d.ill);
         end
      end
   end

   always @(negedge clk) begin
      if (mem_read || mem_write) begin
         if (mem_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: actual=rd %0b wr %0b required=no access (cycle %0d)",
                     mem_read, mem_write, cyc);
         end else begin
            mon_m = mem_q[0];
            strobe_cnt++;
            check("mem_read", mem_read, mon_m.rd);
            check("mem_write", mem_write, mon_m.wr);
            check("mem_address", mem_address, mon_m.addr);
            check("mem_byte_enable", mem_byte_enable, mon_m.be);
            if (mon_m.wmask != 0)
               check("mem_wdata", mem_wdata & mon_m.wmask, mon_m.wdata & mon_m.wmask);
         end
      end else if (strobe_cnt != 0) begin
         mon_m = mem_q.pop_front();
         check("strobe_cycles", 64'(strobe_cnt), 64'(mon_m.ncyc));
         strobe_cnt = 0;
      end
   end

   // d = ACCESS cycle (1-based) in which mem_resp is driven.
   task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int d,
                         input logic [31:0] rd, input int kind, input logic [31:0] exp_rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_wm);
      int        c;
      done_exp_t de;
      mem_exp_t  me;
      c = cyc;
      check({tag, "_ready_idle"}, req_ready, 1'b1);
      de.rdata = exp_rd;
      de.mis   = (kind == K_MIS);
      de.ill   = (kind == K_ILL);
      de.to    = (kind == K_TO);
      de.cyc   = (kind == K_MIS || kind == K_ILL) ? c + 1 : (kind == K_TO ? c + 1 + TO : c + 1 + d);
      done_q.push_back(de);
      if (kind == K_OK || kind == K_TO) begin
         me.rd    = !st;
         me.wr    = st;
         me.addr  = addr & 32'hFFFF_FFFC;
         me.be    = exp_be;
         me.wdata = exp_wd;
         me.wmask = exp_wm;
         me.ncyc  = (kind == K_TO) ? TO : d;
         mem_q.push_back(me);
      end
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom);
      if (kind == K_OK) begin
         repeat (d - 1) begin @(posedge clk); #1; end
         mem_resp  = 1'b1;
         mem_rdata = rd;
         @(posedge clk); #1;
         mem_resp  = 1'b0;
         mem_rdata = $urandom;
      end else if (kind == K_TO) begin
         repeat (TO) begin @(posedge clk); #1; end
      end
      check({tag, "_not_ready_in_done"}, req_ready, 1'b0);
      @(posedge clk); #1;
      check({tag, "_rdata_hold"}, done_rdata, exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=simulation still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int       c;
      mem_exp_t me;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_mem_write", mem_write, 1'b0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_byte_enable", mem_byte_enable, 4'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_done_valid", done_valid, 1'b0);
      check("rst_done_rdata", done_rdata, 32'h0);
      check("rst_done_misaligned", done_misaligned, 1'b0);
      check("rst_done_timeout", done_timeout, 1'b0);
      check("rst_done_illegal", done_illegal, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      //      tag           st  f3      addr          wdata         d  mem_rdata     kind   exp_rdata     be       exp_wdata     wmask
      do_req("lb",          0, 3'b000, 32'h0000_1003, 32'h0,        2, 32'h80FF1234, K_OK,  32'hFFFFFF80, 4'b1000, 32'h0,        32'h0);
      do_req("sh",          1, 3'b001, 32'h0000_2002, 32'h0000ABCD, 1, 32'h55555555, K_OK,  32'h0,        4'b1100, 32'hABCD0000, 32'hFFFF0000);
      do_req("lw_mis",      0, 3'b010, 32'h0000_3001, 32'h0,        0, 32'h0,        K_MIS, 32'h0,        4'b0000, 32'h0,        32'h0);
      do_req("lw_timeout",  0, 3'b010, 32'h0000_0040, 32'h0,        0, 32'h0,        K_TO,  32'h0,        4'b1111, 32'h0,        32'h0);
      do_req("lw_resp_to",  0, 3'b010, 32'h0000_0044, 32'h0,        4, 32'h12345678, K_OK,  32'h12345678, 4'b1111, 32'h0,        32'h0);
      do_req("ld_ill",      0, 3'b011, 32'h0000_0048, 32'h0,        0, 32'h0,        K_ILL, 32'h0,        4'b0000, 32'h0,        32'h0);
      do_req("ld_ill_mis",  0, 3'b011, 32'h0000_0003, 32'h0,        0, 32'h0,        K_ILL, 32'h0,        4'b0000, 32'h0,        32'h0);
      do_req("lh",          0, 3'b001, 32'h0000_0106, 32'h0,        1, 32'h80017777, K_OK,  32'hFFFF8001, 4'b1100, 32'h0,        32'h0);
      do_req("lhu",         0, 3'b101, 32'h0000_0106, 32'h0,        2, 32'h80017777, K_OK,  32'h00008001, 4'b1100, 32'h0,        32'h0);
      do_req("lbu",         0, 3'b100, 32'h0000_0101, 32'h0,        3, 32'h0000A500, K_OK,  32'h000000A5, 4'b0010, 32'h0,        32'h0);
      do_req("lwu_ill",     0, 3'b110, 32'h0000_0010, 32'h0,        0, 32'h0,        K_ILL, 32'h0,        4'b0000, 32'h0,        32'h0);
      do_req("sb",          1, 3'b000, 32'h0000_0203, 32'h0000005A, 2, 32'hFFFFFFFF, K_OK,  32'h0,        4'b1000, 32'h5A000000, 32'hFF000000);
      do_req("sw",          1, 3'b010, 32'h0000_0300, 32'hDEADBEEF, 3, 32'h0,        K_OK,  32'h0,        4'b1111, 32'hDEADBEEF, 32'hFFFFFFFF);
      do_req("sh_mis",      1, 3'b001, 32'h0000_2001, 32'h0000ABCD, 0, 32'h0,        K_MIS, 32'h0,        4'b0000, 32'h0,        32'h0);
      do_req("sd_ill",      1, 3'b011, 32'h0000_0008, 32'h0,        0, 32'h0,        K_ILL, 32'h0,        4'b0000, 32'h0,        32'h0);
      do_req("st100_ill",   1, 3'b100, 32'h0000_0008, 32'h0,        0, 32'h0,        K_ILL, 32'h0,        4'b0000, 32'h0,        32'h0);

      // mem_resp while idle must not start or complete anything
      mem_resp  = 1'b1;
      mem_rdata = 32'hA5A5A5A5;
      repeat (3) begin @(posedge clk); #1; end
      mem_resp  = 1'b0;
      check("idle_resp_no_done", done_valid, 1'b0);
      check("idle_resp_ready", req_ready, 1'b1);

      do_req("lw_pre_rst",  0, 3'b010, 32'h0000_0060, 32'h0,        1, 32'hCAFEF00D, K_OK,  32'hCAFEF00D, 4'b1111, 32'h0,        32'h0);

      // reset during the second ACCESS cycle abandons the load
      c = cyc;
      me.rd = 1'b1; me.wr = 1'b0; me.addr = 32'h50; me.be = 4'b1111;
      me.wdata = 32'h0; me.wmask = 32'h0; me.ncyc = 2;
      mem_q.push_back(me);
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h50;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_in_access_cycle", 64'(cyc), 64'(c + 2));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_abort_mem_read", mem_read, 1'b0);
      check("rst_abort_req_ready", req_ready, 1'b1);
      check("rst_abort_done_valid", done_valid, 1'b0);
      check("rst_abort_done_rdata", done_rdata, 32'h0);
      @(posedge clk); #1;
      check("rst_abort_no_late_done", done_valid, 1'b0);

      do_req("lb_after_rst", 0, 3'b000, 32'h0000_0070, 32'h0,       1, 32'h0000007F, K_OK,  32'h0000007F, 4'b0001, 32'h0,        32'h0);

      repeat (3) begin @(posedge clk); #1; end
      check("done_queue_drained", 64'(done_q.size()), 64'd0);
      check("mem_queue_drained", 64'(mem_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
